// File: rtl/ctrl_unit_pkg.sv
// rtl/ctrl_unit_pkg.sv - shared constants, state and instruction-class types for ctrl_unit
package ctrl_unit_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int ALU_TMO_DEF = 15;
   localparam int INSTR_W     = 16;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LDI = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_HLT = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_READ   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP = 3'd0,
      CLS_HLT = 3'd1,
      CLS_LDI = 3'd2,
      CLS_ALU = 3'd3,
      CLS_ILL = 3'd4
   } instr_class_e;

endpackage

// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - instruction-memory, register-file and ALU signals of ctrl_unit
interface ctrl_unit_if
   import ctrl_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [2:0]         rs1_addr;
   logic [2:0]         rs2_addr;
   logic [2:0]         rd_addr;
   logic               r_w;
   logic               input_length;
   logic [3:0]         alu_op;
   logic               alu_start;
   logic               alu_done;
   logic               wb_sel;
   logic [7:0]         imm;

   modport master (
      output imem_addr, rs1_addr, rs2_addr, rd_addr, r_w, input_length,
             alu_op, alu_start, wb_sel, imm,
      input  imem_rdata, alu_done
   );

   modport slave (
      input  imem_addr, rs1_addr, rs2_addr, rd_addr, r_w, input_length,
             alu_op, alu_start, wb_sel, imm,
      output imem_rdata, alu_done
   );
endinterface

// File: rtl/ctrl_unit_instr_decoder.sv
// rtl/ctrl_unit_instr_decoder.sv - combinational opcode classification and writeback attributes
module ctrl_unit_instr_decoder
   import ctrl_unit_pkg::*;
(
   input  logic [3:0]   i_opcode,
   input  logic [2:0]   i_rd,
   output instr_class_e o_cls,
   output logic         o_legal,
   output logic         o_input_length,
   output logic         o_wb_sel
);

   always_comb begin
      o_cls          = CLS_ILL;
      o_input_length = 1'b0;
      o_wb_sel       = 1'b0;
      case (i_opcode)
         OP_NOP: o_cls = CLS_NOP;
         OP_HLT: o_cls = CLS_HLT;
         OP_LDI: begin
            o_cls    = CLS_LDI;
            o_wb_sel = 1'b1;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: o_cls = CLS_ALU;
         // A 16-bit result lands in rd and rd+1, so rd=7 has no room for the low half.
         OP_MUL: begin
            if (i_rd != 3'd7) begin
               o_cls          = CLS_ALU;
               o_input_length = 1'b1;
            end
         end
         default: o_cls = CLS_ILL;
      endcase
   end

   assign o_legal = (o_cls != CLS_ILL);

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - multi-cycle fetch/decode/execute sequencer driving register file and ALU
module ctrl_unit
   import ctrl_unit_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int ALU_TMO = ALU_TMO_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic        o_halted,
   output logic        o_fault,
   ctrl_unit_if.master bus
);

   localparam int TMO_W = $clog2(ALU_TMO + 2);

   state_e              r_state;
   state_e              w_next;
   logic [PC_W-1:0]     r_pc;
   logic [INSTR_W-1:0]  r_ir;
   logic                r_fault;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_len;
   logic                r_wb_sel;

   instr_class_e        w_cls;
   logic                w_legal;
   logic                w_len;
   logic                w_wb_sel;
   logic                w_tmo_hit;
   logic                w_restart;
   logic                w_pc_inc;

   // Decoded straight from imem_rdata in DECODE; only registered copies reach outputs.
   ctrl_unit_instr_decoder u_dec (
      .i_opcode       (bus.imem_rdata[OPC_HI:OPC_LO]),
      .i_rd           (bus.imem_rdata[RD_HI:RD_LO]),
      .o_cls          (w_cls),
      .o_legal        (w_legal),
      .o_input_length (w_len),
      .o_wb_sel       (w_wb_sel)
   );

   assign w_tmo_hit = (r_state == ST_EXEC) && !bus.alu_done && (r_tmo == TMO_W'(ALU_TMO));
   assign w_restart = ((r_state == ST_IDLE) || (r_state == ST_HALT)) && (w_next == ST_FETCH);
   assign w_pc_inc  = ((r_state == ST_DECODE) && (w_cls == CLS_NOP)) || (r_state == ST_WB);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (i_start) w_next = ST_FETCH;
         ST_HALT:   if (i_start && !r_fault) w_next = ST_FETCH;
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            case (w_cls)
               CLS_NOP: w_next = ST_FETCH;
               CLS_LDI: w_next = ST_WB;
               CLS_ALU: w_next = ST_READ;
               default: w_next = ST_HALT;
            endcase
         end
         ST_READ:   w_next = ST_EXEC;
         ST_EXEC: begin
            if (bus.alu_done)   w_next = ST_WB;
            else if (w_tmo_hit) w_next = ST_HALT;
         end
         ST_WB:     w_next = ST_FETCH;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_ir     <= '0;
         r_fault  <= 1'b0;
         r_tmo    <= '0;
         r_len    <= 1'b0;
         r_wb_sel <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_restart)     r_pc <= '0;
         else if (w_pc_inc) r_pc <= r_pc + PC_W'(1);
         if (r_state == ST_DECODE) begin
            r_ir     <= bus.imem_rdata;
            r_len    <= w_len;
            r_wb_sel <= w_wb_sel;
         end
         if (((r_state == ST_DECODE) && !w_legal) || w_tmo_hit) r_fault <= 1'b1;
         r_tmo <= ((r_state == ST_EXEC) && (w_next == ST_EXEC)) ? r_tmo + TMO_W'(1) : '0;
      end
   end

   assign bus.imem_addr    = r_pc;
   assign bus.rs1_addr     = r_ir[RS1_HI:RS1_LO];
   assign bus.rs2_addr     = r_ir[RS2_HI:RS2_LO];
   assign bus.rd_addr      = r_ir[RD_HI:RD_LO];
   assign bus.alu_op       = r_ir[OPC_HI:OPC_LO];
   assign bus.imm          = r_ir[IMM_HI:IMM_LO];
   assign bus.r_w          = (r_state != ST_WB);
   assign bus.input_length = (r_state == ST_WB) && r_len;
   assign bus.wb_sel       = (r_state == ST_WB) && r_wb_sel;
   assign bus.alu_start    = (r_state == ST_EXEC) && (r_tmo == '0);
   assign o_halted         = (r_state == ST_HALT);
   assign o_fault          = r_fault;

endmodule
